debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 187 ++++++++++++++++++
 tb/tb_debounce_bank.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// -----------------------------------------------------------------------------
// debounce_bank
//
// Purpose:
//   A bank of independent debouncers for raw mechanical inputs such as
//   buttons and switches. Each channel works in four steps:
//     1. It synchronises the raw input through a short flop chain.
//     2. It accepts a new level only after CYCLES consecutive synchronised
//        samples disagree with the current debounced level. A single
//        agreeing sample restarts the count.
//     3. It emits one-cycle rise and fall pulses in the same cycle the
//        debounced level changes.
//     4. Optionally, it emits a one-cycle long-press pulse once the level
//        has been held high for HOLD_CYCLES cycles.
//
// Parameters:
//   CHANNELS    number of independent channels (>= 1)
//   CYCLES      consecutive disagreeing samples needed to accept a level (>= 1)
//   SYNC_STAGES synchroniser depth per channel (>= 1)
//   HOLD_CYCLES high time before long_press fires; 0 removes the hold logic
//
// Ports:
//   clk         sole clock, all state on the rising edge
//   rst         synchronous, active-high reset
//   in          raw asynchronous inputs, one bit per channel
//   out         debounced level per channel (registered)
//   rise        one-cycle pulse when out goes 0->1
//   fall        one-cycle pulse when out goes 1->0
//   long_press  one-cycle pulse when out has been 1 for HOLD_CYCLES cycles
//   any_change  OR of all rise and fall bits, in the same cycle
//
// Latency:
//   A clean level set up before edge 0 reaches out after edge
//   SYNC_STAGES+CYCLES-1.
// -----------------------------------------------------------------------------
module debounce_bank #(
    parameter int CHANNELS    = 8,
    parameter int CYCLES      = 10,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] long_press,
    output logic                any_change
);

    // Width of the debounce counter. It must be able to hold 0..CYCLES.
    localparam int CW = $clog2(CYCLES + 1);

    // Terminal count. A channel that disagrees while sitting at this count
    // accepts the new level on this edge.
    localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

    // One bit per channel: this channel accepts a new level on this edge.
    // The bits are gathered into one vector so that any_change can be
    // registered alongside the per-channel pulses.
    logic [CHANNELS-1:0] accept;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch

            // Synchroniser chain. Stage 0 samples the raw pin.
            logic [SYNC_STAGES-1:0] sync_q;

            // Synchronised sample used by all of the comparisons below.
            logic                   s;

            // The synchronised sample disagrees with the debounced level.
            logic                   differ;

            // Debounce counter, debounced level and registered pulses.
            logic [CW-1:0]          cnt_q;
            logic                   out_q;
            logic                   rise_q;
            logic                   fall_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    // NOTE: non-blocking assignments let each stage capture
                    // the previous stage's old value. A blocking chain would
                    // collapse into a single flop.
                    sync_q[0] <= in[gi];
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end

            assign s          = sync_q[SYNC_STAGES-1];
            assign differ     = s ^ out_q;
            assign accept[gi] = differ && (cnt_q == CNT_LAST);

            // Debounce counter.
            // - It counts only while the sample disagrees with out.
            // - Any agreeing sample clears it, so a glitch earns no partial
            //   credit.
            // - Accepting the new level also clears it, so it never wraps.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q  <= '0;
                    out_q  <= 1'b0;
                    rise_q <= 1'b0;
                    fall_q <= 1'b0;
                end else begin
                    rise_q <= accept[gi] & s;
                    fall_q <= accept[gi] & ~s;
                    if (accept[gi]) begin
                        out_q <= s;
                        cnt_q <= '0;
                    end else if (differ) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
            end

            assign out[gi]  = out_q;
            assign rise[gi] = rise_q;
            assign fall[gi] = fall_q;

            if (HOLD_CYCLES > 0) begin : g_hold

                // Width of the hold counter. It must be able to hold
                // 0..HOLD_CYCLES.
                localparam int HW = $clog2(HOLD_CYCLES + 1);

                // Saturation value of the hold counter.
                localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

                // Count one below saturation. When the counter steps from
                // here to HOLD_MAX, long_press fires.
                localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

                logic [HW-1:0] hc_q;
                logic          lp_q;

                // Hold counter.
                // - Clearing while out is low also covers the rising edge
                //   itself: on that edge out is still 0.
                // - The counter saturates at HOLD_MAX. The pulse fires only
                //   on the step into saturation, so a long hold does not
                //   make it repeat.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        hc_q <= '0;
                        lp_q <= 1'b0;
                    end else begin
                        lp_q <= out_q && (hc_q == HOLD_LAST);
                        if (!out_q) begin
                            hc_q <= '0;
                        end else if (hc_q != HOLD_MAX) begin
                            hc_q <= hc_q + HW'(1);
                        end
                    end
                end

                assign long_press[gi] = lp_q;

            end else begin : g_no_hold

                // Long-press detection is disabled: no hold counter exists.
                assign long_press[gi] = 1'b0;

            end
        end
    endgenerate

    // any_change is registered from the same accept terms that drive the
    // rise and fall flops, so it lines up with them exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_change <= 1'b0;
        end else begin
            any_change <= |accept;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// -----------------------------------------------------------------------------
// tb_debounce_bank
//
// Self-checking bench for debounce_bank, built with:
//   8 channels, 10 debounce cycles, 2 sync stages, 20 hold cycles.
//
// The reference model does not count. It keeps a history of every sampled
// input vector and evaluates the behaviour directly from that history:
//   - The synchronised sample at edge e is the raw input from edge
//     e-SYNC, or 0 if a reset fell inside that window.
//   - out flips at edge t when the last CYCLES synchronised samples all
//     disagree with out, and the whole window lies after the previous flip
//     and after the last reset.
//   - long_press fires at the edge exactly HOLD edges after the latest rise,
//     provided out was still high going into that edge.
// -----------------------------------------------------------------------------
module tb_debounce_bank;

    localparam int CH   = 8;
    localparam int CYC  = 10;
    localparam int SYN  = 2;
    localparam int HOLD = 20;
    localparam int MAXE = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CH-1:0] in  = '0;
    logic [CH-1:0] out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] long_press;
    logic          any_change;

    int checks = 0;
    int errors = 0;

    debounce_bank #(
        .CHANNELS   (CH),
        .CYCLES     (CYC),
        .SYNC_STAGES(SYN),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .out       (out),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press),
        .any_change(any_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [CH-1:0] in_hist [MAXE];
    int            edge_n      = 0;
    int            last_rst    = -1000;
    bit            model_valid = 1'b0;
    int            last_change [CH];
    int            rise_edge   [CH];
    logic [CH-1:0] m_out  = '0;
    logic [CH-1:0] m_rise = '0;
    logic [CH-1:0] m_fall = '0;
    logic [CH-1:0] m_lp   = '0;
    logic          m_any  = 1'b0;

    // Synchronised sample seen going into edge e.
    function automatic logic s_pre(input int e, input int ch);
        if (e - SYN < 0 || last_rst >= e - SYN) return 1'b0;
        return in_hist[(e - SYN) % MAXE][ch];
    endfunction

    always @(posedge clk) begin
        logic [CH-1:0] nr, nf, nl;
        bit all_diff;
        if (rst) begin
            model_valid = 1'b1;
            last_rst    = edge_n;
            for (int c = 0; c < CH; c++) begin
                last_change[c] = edge_n;
                rise_edge[c]   = -100000;
            end
            m_out  = '0;
            m_rise = '0;
            m_fall = '0;
            m_lp   = '0;
            m_any  = 1'b0;
        end else begin
            nr = '0;
            nf = '0;
            nl = '0;
            for (int c = 0; c < CH; c++) begin
                if (m_out[c] && (edge_n - rise_edge[c] == HOLD)) nl[c] = 1'b1;
                if (edge_n - CYC + 1 > last_change[c]) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < CYC; k++)
                        if (s_pre(edge_n - k, c) == m_out[c]) all_diff = 1'b0;
                    if (all_diff) begin
                        if (!m_out[c]) begin
                            nr[c]        = 1'b1;
                            rise_edge[c] = edge_n;
                        end else begin
                            nf[c] = 1'b1;
                        end
                        m_out[c]       = ~m_out[c];
                        last_change[c] = edge_n;
                    end
                end
            end
            m_rise = nr;
            m_fall = nf;
            m_lp   = nl;
            m_any  = |(nr | nf);
        end
        in_hist[edge_n % MAXE] = in;
        edge_n++;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("out",        out,        m_out);
            check("rise",       rise,       m_rise);
            check("fall",       fall,       m_fall);
            check("long_press", long_press, m_lp);
            check("any_change", any_change, m_any);
        end
    end

    // Pulse counters taken from the DUT, used by the literal checks below.
    int rise_cnt [CH];
    int fall_cnt [CH];
    int lp_cnt   [CH];

    initial begin
        for (int c = 0; c < CH; c++) begin
            rise_cnt[c] = 0;
            fall_cnt[c] = 0;
            lp_cnt[c]   = 0;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int c = 0; c < CH; c++) begin
                if (rise[c] === 1'b1)       rise_cnt[c]++;
                if (fall[c] === 1'b1)       fall_cnt[c]++;
                if (long_press[c] === 1'b1) lp_cnt[c]++;
            end
        end
    end

    task automatic wait_n(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        rst = 1'b1;
        in  = '0;
        wait_n(3);
        check("rst_out",  out,        0);
        check("rst_rise", rise,       0);
        check("rst_lp",   long_press, 0);
        check("rst_any",  any_change, 0);
        rst = 1'b0;
        wait_n(2);

        // in[0] 0->1: out rises after edge 11, along with rise and any_change.
        in[0] = 1'b1;
        wait_n(11);
        check("t1_out_early", out, 8'h00);
        wait_n(1);
        check("t1_out",  out,        8'h01);
        check("t1_rise", rise,       8'h01);
        check("t1_any",  any_change, 1);
        wait_n(1);
        check("t1_rise_gone", rise,       8'h00);
        check("t1_any_gone",  any_change, 0);
        wait_n(5);

        // A 9-cycle pulse on in[3] is rejected.
        in[3] = 1'b1;
        wait_n(9);
        in[3] = 1'b0;
        wait_n(20);
        check("t2_short_rise", rise_cnt[3], 0);
        check("t2_short_fall", fall_cnt[3], 0);

        // A 10-cycle pulse on in[3] is accepted: rise after edge 11,
        // fall after edge 21.
        in[3] = 1'b1;
        wait_n(10);
        in[3] = 1'b0;
        wait_n(2);
        check("t2_out_hi", out[3], 1);
        wait_n(9);
        check("t2_out_still_hi", out[3], 1);
        wait_n(1);
        check("t2_out_lo", out[3], 0);
        check("t2_fall",   fall[3], 1);
        wait_n(5);
        check("t2_rise_cnt", rise_cnt[3], 1);
        check("t2_fall_cnt", fall_cnt[3], 1);

        // in[1] bounces (toggle every 3 cycles), then settles high.
        for (int i = 0; i < 10; i++) begin
            in[1] = ~in[1];
            wait_n(3);
        end
        in[1] = 1'b1;
        wait_n(11);
        check("t3_out_early", out[1], 0);
        wait_n(1);
        check("t3_out",  out[1],  1);
        check("t3_rise", rise[1], 1);
        wait_n(3);
        check("t3_rise_cnt", rise_cnt[1], 1);
        check("t3_fall_cnt", fall_cnt[1], 0);
        check("t1_lp_cnt0",  lp_cnt[0],   1);

        // in[2] held: long_press fires 20 cycles after rise, exactly once,
        // and fires again after a release and re-press.
        in[2] = 1'b1;
        wait_n(12);
        check("t4_rise", rise[2], 1);
        wait_n(19);
        check("t4_lp_early", long_press[2], 0);
        wait_n(1);
        check("t4_lp", long_press[2], 1);
        wait_n(40);
        check("t4_lp_once", lp_cnt[2], 1);
        in[2] = 1'b0;
        wait_n(15);
        in[2] = 1'b1;
        wait_n(34);
        check("t4_lp_again", lp_cnt[2], 2);

        // Reset 5 cycles into a count on in[5]. After release, every held
        // channel must wait the full latency again.
        in[5] = 1'b1;
        wait_n(7);
        rst = 1'b1;
        wait_n(1);
        check("t5_out", out,        0);
        check("t5_lp",  long_press, 0);
        check("t5_any", any_change, 0);
        rst = 1'b0;
        wait_n(11);
        check("t5_out_early", out, 8'h00);
        wait_n(1);
        check("t5_out_late", out,        8'h27);
        check("t5_rise",     rise,       8'h27);
        check("t5_any_late", any_change, 1);
        wait_n(3);

        // Release everything, then raise all 8 inputs on the same edge.
        in = '0;
        wait_n(15);
        check("t6_all_low", out, 8'h00);
        in = 8'hFF;
        wait_n(12);
        check("t6_rise_all", rise,       8'hFF);
        check("t6_out_all",  out,        8'hFF);
        check("t6_any",      any_change, 1);
        wait_n(1);
        check("t6_any_gone",  any_change, 0);
        check("t6_rise_gone", rise,       8'h00);
        wait_n(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
